button_sync_debounce: RTL and testbench
=======================================

Name: button_sync_debounce

Overview:
- Front-end conditioning stage for the four push buttons (C4, E4, AB4, C5) on the 50 MHz board clock.
- Each raw pin passes through a multi-flop synchronizer, then a counter-based debounce FSM.
- Each channel produces a one-cycle press pulse (result_*) that feeds the state-select logic directly, plus a debounced level output.
- All four channels are fully independent; priority between buttons is resolved downstream, not here.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive identical synchronized samples needed to accept a level change (10 ms at 50 MHz). Must be ≥2.
- SYNC_STAGES, 2, synchronizer flop depth. Must be ≥2.
- CNT_W, derived localparam = clog2(DEBOUNCE_CYCLES), width of the per-channel counter (19 at default). Not overridable.

Ports:
- clk_50MHz input 1: 50 MHz board clock, sole clock.
- rst input 1: asynchronous, active-high reset.
- btn_c4 input 1: raw asynchronous button pin C4, active-high.
- btn_e4 input 1: raw asynchronous button pin E4, active-high.
- btn_ab4 input 1: raw asynchronous button pin AB4, active-high.
- btn_c5 input 1: raw asynchronous button pin C5, active-high.
- result_c4 output 1: one-cycle pulse on accepted press of C4.
- result_e4 output 1: one-cycle pulse on accepted press of E4.
- result_ab4 output 1: one-cycle pulse on accepted press of AB4.
- result_c5 output 1: one-cycle pulse on accepted press of C5.
- level output 4: debounced levels {c5, ab4, e4, c4}.

Behaviour:
- Reset: asynchronous and active-high. While rst is high, all synchronizer flops are 0, every FSM is in LOW, counters are 0, all result_* are 0 and level is 4'b0000. All outputs are registered.
- Synchronizer: a SYNC_STAGES-deep flop chain per pin. The chain output is s.
- FSM states per channel: LOW, CONF_HIGH, HIGH, CONF_LOW.
- LOW: if s=1, go to CONF_HIGH with cnt=1. Otherwise stay.
- CONF_HIGH:
  - If s=0, return to LOW with cnt=0. This is a bounce and no pulse is produced.
  - If s=1 and cnt==DEBOUNCE_CYCLES-1, go to HIGH, set level=1, and assert result for exactly one cycle.
  - Otherwise cnt increments by 1.
- HIGH: if s=0, go to CONF_LOW with cnt=1.
- CONF_LOW:
  - If s=1, return to HIGH with cnt=0.
  - If s=0 and cnt==DEBOUNCE_CYCLES-1, go to LOW and set level=0. No pulse is produced on release.
  - Otherwise cnt increments.
- Net rule: a level is accepted after DEBOUNCE_CYCLES consecutive identical samples of s.
- Latency: take edge 0 as the first clock edge that samples the pin high.
  - s is high after edge SYNC_STAGES-1.
  - The FSM accepts the press at edge SYNC_STAGES+DEBOUNCE_CYCLES-1.
  - result is high for the single cycle following that edge.
  - Release latency to level=0 is identical.
- A held button produces exactly one pulse. No auto-repeat.
- cnt never exceeds DEBOUNCE_CYCLES-1. No wrap-around is possible.
- Simultaneous presses on several channels produce pulses in the same cycle.
- Reset asserted mid-confirmation aborts the confirmation with no pulse.
- A pin held high through reset release is treated as a new press and pulses after the normal latency.

Decomposition:
- Shared package/include holds:
  - the FSM state encoding: LOW=2'b00, CONF_HIGH=2'b01, HIGH=2'b10, CONF_LOW=2'b11;
  - the default DEBOUNCE_CYCLES and SYNC_STAGES constants;
  - the clog2 function.
- Sub-module debounce_channel (synchronizer, counter and FSM for one pin) is instantiated four times by the top level.

Test Plan (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Clean press: btn_c4 rises before edge 0 and is held → result_c4=1 for only the cycle after edge 5, level[0]=1 from then on, all other results 0.
- Bounce: btn_e4 high for 2 cycles, low for 1, then high and held → the 2-cycle glitch gives no pulse; a single result_e4 pulse follows 6 edges after the final rise.
- Release: after a confirmed press, btn_ab4 drops for 3 cycles then returns high → level[2] stays 1 with no pulse; a sustained drop clears level[2] 6 edges later with no pulse.
- Simultaneous: btn_c4 and btn_c5 rise on the same edge → result_c4 and result_c5 pulse in the same cycle; level=4'b1001.
- Reset mid-confirm: assert rst 4 edges after btn_c5 rises → no pulse, all outputs 0. Release rst with btn_c5 still high → pulse 6 edges after the first post-reset edge.
- Long hold: btn_e4 held 100 cycles → exactly one result_e4 pulse.

Source files
------------

// File: rtl/button_sync_debounce_pkg.sv
`default_nettype none
// ============================================================================
// button_sync_debounce_pkg : shared debounce state encoding, defaults, clog2
// Revision: 1.0
// ============================================================================
package button_sync_debounce_pkg;

   typedef enum logic [1:0] {
      ST_LOW       = 2'b00,
      ST_CONF_HIGH = 2'b01,
      ST_HIGH      = 2'b10,
      ST_CONF_LOW  = 2'b11
   } deb_state_t;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
   localparam int DEFAULT_SYNC_STAGES     = 2;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((64'd1 << i) < 64'(value)) r = i + 1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/button_sync_debounce_channel.sv
`default_nettype none
// ============================================================================
// debounce_channel : synchronizer + counter-based debounce FSM for one pin
// Revision: 1.0
// ============================================================================
module debounce_channel
   import button_sync_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic pulse,
   output logic level
);

   localparam int             CNT_W    = clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   deb_state_t             state, state_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic                   level_nxt, pulse_nxt;

   assign s = sync[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync  <= '0;
         state <= ST_LOW;
         cnt   <= '0;
         level <= 1'b0;
         pulse <= 1'b0;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], pin};
         state <= state_nxt;
         cnt   <= cnt_nxt;
         level <= level_nxt;
         pulse <= pulse_nxt;
      end
   end

   // cnt counts consecutive matching samples, so it tops out at CNT_LAST
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      level_nxt = level;
      pulse_nxt = 1'b0;
      case (state)
         ST_LOW: begin
            if (s) begin
               state_nxt = ST_CONF_HIGH;
               cnt_nxt   = CNT_W'(1);
            end
         end
         ST_CONF_HIGH: begin
            if (!s) begin
               state_nxt = ST_LOW;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = ST_HIGH;
               cnt_nxt   = '0;
               level_nxt = 1'b1;
               pulse_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_HIGH: begin
            if (!s) begin
               state_nxt = ST_CONF_LOW;
               cnt_nxt   = CNT_W'(1);
            end
         end
         ST_CONF_LOW: begin
            if (s) begin
               state_nxt = ST_HIGH;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = ST_LOW;
               cnt_nxt   = '0;
               level_nxt = 1'b0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = ST_LOW;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/button_sync_debounce.sv
`default_nettype none
// ============================================================================
// button_sync_debounce : four independent synchronize/debounce button channels
// Revision: 1.0
// ============================================================================
module button_sync_debounce
   import button_sync_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
   input  logic       clk_50MHz,
   input  logic       rst,
   input  logic       btn_c4,
   input  logic       btn_e4,
   input  logic       btn_ab4,
   input  logic       btn_c5,
   output logic       result_c4,
   output logic       result_e4,
   output logic       result_ab4,
   output logic       result_c5,
   output logic [3:0] level
);

   logic [3:0] pins;
   logic [3:0] pulses;

   // bit order matches level: {c5, ab4, e4, c4}
   assign pins = {btn_c5, btn_ab4, btn_e4, btn_c4};

   for (genvar i = 0; i < 4; i++) begin : g_chan
      debounce_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .SYNC_STAGES    (SYNC_STAGES)
      ) u_chan (
         .clk  (clk_50MHz),
         .rst  (rst),
         .pin  (pins[i]),
         .pulse(pulses[i]),
         .level(level[i])
      );
   end

   assign result_c4  = pulses[0];
   assign result_e4  = pulses[1];
   assign result_ab4 = pulses[2];
   assign result_c5  = pulses[3];

endmodule
`default_nettype wire

// File: tb/tb_button_sync_debounce.sv
`default_nettype none
// ============================================================================
// tb_button_sync_debounce : vector-table bench for button_sync_debounce
// Revision: 1.0
// ============================================================================
module tb_button_sync_debounce;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_c4, btn_e4, btn_ab4, btn_c5;
   logic       result_c4, result_e4, result_ab4, result_c5;
   logic [3:0] level;
   logic [3:0] res_bus;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] btn;
      logic [3:0] res;
      logic [3:0] lvl;
   } vec_t;

   vec_t vecs[$];

   button_sync_debounce #(
      .DEBOUNCE_CYCLES(4),
      .SYNC_STAGES    (2)
   ) dut (
      .clk_50MHz (clk),
      .rst       (rst),
      .btn_c4    (btn_c4),
      .btn_e4    (btn_e4),
      .btn_ab4   (btn_ab4),
      .btn_c5    (btn_c5),
      .result_c4 (result_c4),
      .result_e4 (result_e4),
      .result_ab4(result_ab4),
      .result_c5 (result_c5),
      .level     (level)
   );

   always #5 clk = ~clk;

   assign res_bus = {result_c5, result_ab4, result_e4, result_c4};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_btn(input logic [3:0] b);
      {btn_c5, btn_ab4, btn_e4, btn_c4} = b;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [3:0] b, input logic [3:0] r, input logic [3:0] l, input int n);
      for (int i = 0; i < n; i++) vecs.push_back('{btn: b, res: r, lvl: l});
   endtask

   initial begin
      int pulse_cnt;

      // btn/res/lvl bit order is {c5, ab4, e4, c4}
      add(4'b0000, 4'b0000, 4'b0000, 3);
      // clean press of c4
      add(4'b0001, 4'b0000, 4'b0000, 5);
      add(4'b0001, 4'b0001, 4'b0001, 1);
      add(4'b0001, 4'b0000, 4'b0001, 2);
      // e4 bounce: 2 high, 1 low, then held
      add(4'b0011, 4'b0000, 4'b0001, 2);
      add(4'b0001, 4'b0000, 4'b0001, 1);
      add(4'b0011, 4'b0000, 4'b0001, 5);
      add(4'b0011, 4'b0010, 4'b0011, 1);
      add(4'b0011, 4'b0000, 4'b0011, 2);
      // ab4 press, 3-cycle dropout, then sustained release
      add(4'b0111, 4'b0000, 4'b0011, 5);
      add(4'b0111, 4'b0100, 4'b0111, 1);
      add(4'b0111, 4'b0000, 4'b0111, 1);
      add(4'b0011, 4'b0000, 4'b0111, 3);
      add(4'b0111, 4'b0000, 4'b0111, 4);
      add(4'b0011, 4'b0000, 4'b0111, 5);
      add(4'b0011, 4'b0000, 4'b0011, 2);
      // release c4 and e4 together
      add(4'b0000, 4'b0000, 4'b0011, 5);
      add(4'b0000, 4'b0000, 4'b0000, 2);
      // simultaneous c4 + c5
      add(4'b1001, 4'b0000, 4'b0000, 5);
      add(4'b1001, 4'b1001, 4'b1001, 1);
      add(4'b1001, 4'b0000, 4'b1001, 1);
      add(4'b0000, 4'b0000, 4'b1001, 5);
      add(4'b0000, 4'b0000, 4'b0000, 2);

      rst = 1'b1;
      set_btn(4'b0000);
      repeat (3) tick();
      check("reset res", 32'(res_bus), 32'h0);
      check("reset level", 32'(level), 32'h0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         set_btn(vecs[i].btn);
         tick();
         check($sformatf("vec%0d res", i), 32'(res_bus), 32'(vecs[i].res));
         check($sformatf("vec%0d level", i), 32'(level), 32'(vecs[i].lvl));
      end

      // reset asserted four edges into a c5 confirmation
      set_btn(4'b1000);
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("c5 confirm%0d res", k), 32'(res_bus), 32'h0);
      end
      rst = 1'b1;
      #1;
      check("async rst res", 32'(res_bus), 32'h0);
      check("async rst level", 32'(level), 32'h0);
      repeat (2) begin
         tick();
         check("in rst res", 32'(res_bus), 32'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 7; k++) begin
         tick();
         check($sformatf("post rst%0d res", k), 32'(res_bus), (k == 5) ? 32'h8 : 32'h0);
         check($sformatf("post rst%0d level", k), 32'(level), (k >= 5) ? 32'h8 : 32'h0);
      end
      set_btn(4'b0000);
      repeat (7) tick();
      check("c5 released level", 32'(level), 32'h0);

      // long hold on e4
      set_btn(4'b0010);
      pulse_cnt = 0;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (result_e4) pulse_cnt++;
      end
      check("long hold pulses", 32'(pulse_cnt), 32'd1);
      check("long hold level", 32'(level), 32'h2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
